// File: rtl/scm_fifo_pkg.sv
// Shared defaults and types for the scm65-backed FIFO controller.
// The optional direct-to-output bypass is enabled by defining SCM_FIFO_BYPASS_EN.
package scm_fifo_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 16;

  typedef logic [AW_DEF-1:0] ptr_t;
  typedef logic [AW_DEF+1:0] count_t;

endpackage

// File: rtl/scm_fifo_ostage.sv
// Two-entry in-order output buffer that hides the macro read latency.
// OUT_DATA always comes from the head register, never straight from the macro.
module scm_fifo_ostage
  import scm_fifo_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cap_vld_i,
  input  logic [DW-1:0] cap_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    occ_o
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    occ_q, occ_d;
  logic          pop;

  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = head_q;
  assign occ_o       = occ_q;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q + {1'b0, cap_vld_i} - {1'b0, pop};
    case ({cap_vld_i, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = cap_data_i;
        else               tail_d = cap_data_i;
      end
      2'b01: head_d = tail_q;
      2'b11: begin
        // With two held, the tail advances and the new word takes its slot.
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = cap_data_i;
        end else begin
          head_d = cap_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/scm_fifo_ctrl.sv
// Synchronous FIFO controller around the 16x16 scm65 macro with valid/ready on both ends.
// Define SCM_FIFO_BYPASS_EN to let pushes into an idle FIFO skip the macro.
module scm_fifo_ctrl
  import scm_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] OUT_DATA,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_WADDR,
  output logic [DW-1:0] MEM_DIN,
  output logic          MEM_RE,
  output logic [AW-1:0] MEM_RADDR,
  input  logic [DW-1:0] MEM_DOUT,
  output logic [AW+1:0] COUNT,
  output logic          FULL,
  output logic          EMPTY
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   mem_cnt_q, mem_cnt_d;
  logic          rd_inflight_q, rd_inflight_d;
  logic [1:0]    occ;
  logic [2:0]    pend;
  logic          pop, push, mem_push, byp, rd_issue, cap_vld;
  logic [DW-1:0] cap_data;

  // IN_READY is a pure function of registered state.
  assign IN_READY = (mem_cnt_q < DEPTH_C);
  assign FULL     = !IN_READY;
  assign pop      = OUT_VALID & OUT_READY;
  assign push     = IN_VALID & IN_READY & RSTN;

  // Words already owed to the output stage after this cycle's pop.
  assign pend     = {1'b0, occ} + {2'b0, rd_inflight_q} - {2'b0, pop};
  assign rd_issue = (mem_cnt_q != '0) && (pend < 3'd2);

`ifdef SCM_FIFO_BYPASS_EN
  logic [1:0] occ_left;
  assign occ_left = occ - {1'b0, pop};
  assign byp      = push && (mem_cnt_q == '0) && !rd_inflight_q && (occ_left < 2'd2);
`else
  assign byp      = 1'b0;
`endif

  assign mem_push = push & !byp;
  assign cap_vld  = rd_inflight_q | byp;
  assign cap_data = byp ? IN_DATA : MEM_DOUT;

  assign MEM_WE    = mem_push;
  assign MEM_WADDR = wptr_q;
  assign MEM_DIN   = IN_DATA;
  assign MEM_RE    = rd_issue;
  assign MEM_RADDR = rptr_q;

  assign COUNT = (AW+2)'(mem_cnt_q) + (AW+2)'(rd_inflight_q) + (AW+2)'(occ);
  assign EMPTY = (COUNT == '0);

  always_comb begin
    wptr_d        = wptr_q + AW'(mem_push);
    rptr_d        = rptr_q + AW'(rd_issue);
    mem_cnt_d     = mem_cnt_q + (AW+1)'(mem_push) - (AW+1)'(rd_issue);
    rd_inflight_d = rd_issue;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  scm_fifo_ostage #(.DW(DW)) u_ostage (
    .clk_i       (CLK),
    .rst_ni      (RSTN),
    .cap_vld_i   (cap_vld),
    .cap_data_i  (cap_data),
    .out_valid_o (OUT_VALID),
    .out_ready_i (OUT_READY),
    .out_data_o  (OUT_DATA),
    .occ_o       (occ)
  );

endmodule

// File: tb/tb_scm_fifo_ctrl.sv
// Scoreboard bench for scm_fifo_ctrl with a behavioural scm65 macro (1-cycle read latency).
// Honours SCM_FIFO_BYPASS_EN for the latency-dependent expectations.
module tb_scm_fifo_ctrl;
  import scm_fifo_pkg::*;

`ifdef SCM_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic        CLK, RSTN;
  logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [15:0] IN_DATA, OUT_DATA, MEM_DIN, MEM_DOUT;
  logic        MEM_WE, MEM_RE;
  logic [3:0]  MEM_WADDR, MEM_RADDR;
  count_t      COUNT;
  logic        FULL, EMPTY;

  scm_fifo_ctrl dut (
    .CLK(CLK), .RSTN(RSTN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .MEM_WE(MEM_WE), .MEM_WADDR(MEM_WADDR), .MEM_DIN(MEM_DIN),
    .MEM_RE(MEM_RE), .MEM_RADDR(MEM_RADDR), .MEM_DOUT(MEM_DOUT),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
  );

  // Behavioural macro: synchronous write, registered read data.
  logic [15:0] mem [16];
  logic [15:0] dout_q;
  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_WADDR] <= MEM_DIN;
    if (MEM_RE) dout_q <= mem[MEM_RADDR];
  end
  assign MEM_DOUT = dout_q;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: scoreboard, stall hold and address sequencing.
  logic        hold_pend = 1'b0;
  logic [15:0] hold_data = '0;
  logic [3:0]  ewp = '0, erp = '0;
  always @(negedge CLK) begin
    if (RSTN) begin
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) chk("sb_unexpected", OUT_DATA, 32'hFFFF_FFFF);
        else chk("sb_data", OUT_DATA, exp_q.pop_front());
      end
      if (IN_VALID && IN_READY) exp_q.push_back(IN_DATA);
      if (hold_pend) begin
        chk("hold_valid", OUT_VALID, 1);
        chk("hold_data", OUT_DATA, hold_data);
      end
      if (MEM_WE) begin chk("waddr_seq", MEM_WADDR, ewp); ewp = ewp + 4'd1; end
      if (MEM_RE) begin chk("raddr_seq", MEM_RADDR, erp); erp = erp + 4'd1; end
      hold_pend = OUT_VALID && !OUT_READY;
      hold_data = OUT_DATA;
    end else begin
      hold_pend = 1'b0;
      ewp = '0;
      erp = '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  int acc, ncyc;
  logic took;

  initial begin
    RSTN = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
    // Reset with random inputs
    repeat (3) begin
      cyc();
      IN_VALID = 1'($urandom_range(0, 1));
      IN_DATA = 16'($urandom);
      OUT_READY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_we", MEM_WE, 0);
      chk("rst_re", MEM_RE, 0);
      chk("rst_count", COUNT, 0);
      chk("rst_empty", EMPTY, 1);
      chk("rst_in_ready", IN_READY, 1);
      chk("rst_full", FULL, 0);
      chk("rst_waddr", MEM_WADDR, 0);
      chk("rst_raddr", MEM_RADDR, 0);
      chk("rst_out_data", OUT_DATA, 0);
      chk("rst_din", MEM_DIN, IN_DATA);
    end
    cyc();
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(negedge CLK);
    RSTN = 1'b1;
    cyc();

    // Single word
    IN_VALID = 1'b1; IN_DATA = 16'hA5A5;
    @(negedge CLK);
`ifdef SCM_FIFO_BYPASS_EN
    chk("sw_we", MEM_WE, 0);
`else
    chk("sw_we", MEM_WE, 1);
    chk("sw_waddr", MEM_WADDR, 0);
    chk("sw_din", MEM_DIN, 16'hA5A5);
`endif
    for (int c = 1; c <= 4; c++) begin
      cyc();
      IN_VALID = 1'b0;
      @(negedge CLK);
`ifndef SCM_FIFO_BYPASS_EN
      if (c == 1) begin
        chk("sw_re", MEM_RE, 1);
        chk("sw_raddr", MEM_RADDR, 0);
      end
`endif
      chk("sw_valid", OUT_VALID, (c == LAT) ? 1 : 0);
      if (c == LAT) chk("sw_data", OUT_DATA, 16'hA5A5);
      if (c == LAT + 1) chk("sw_empty", EMPTY, 1);
    end

    // Fill with consumer stalled
    cyc();
    OUT_READY = 1'b0;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      IN_VALID = 1'b1;
      IN_DATA = 16'(acc);
      @(negedge CLK);
      took = IN_READY;
      cyc();
      if (took) acc++;
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("fill_accepted", acc, 18);
    chk("fill_count", COUNT, 18);
    chk("fill_full", FULL, 1);
    chk("fill_in_ready", IN_READY, 0);
    cyc();
    OUT_READY = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      chk("drain_valid", OUT_VALID, 1);
      chk("drain_data", OUT_DATA, i);
      cyc();
    end
    @(negedge CLK);
    chk("drain_empty", EMPTY, 1);
    cyc();

    // Streaming throughput across the address wrap
    IN_VALID = 1'b1; IN_DATA = 16'h0100;
    for (int c = 0; c < LAT + 40; c++) begin
      @(negedge CLK);
      if (c < 40) chk("tp_in_ready", IN_READY, 1);
      if (c >= LAT) begin
        chk("tp_valid", OUT_VALID, 1);
        chk("tp_data", OUT_DATA, 16'h0100 + 16'(c - LAT));
      end
      cyc();
      if (c + 1 < 40) IN_DATA = 16'h0100 + 16'(c + 1);
      else IN_VALID = 1'b0;
    end
    @(negedge CLK);
    chk("tp_empty", EMPTY, 1);
    cyc();

    // Backpressure: OUT_READY toggles, producer random
    acc = 0; ncyc = 0;
    IN_VALID = 1'b1; IN_DATA = 16'($urandom);
    while (acc < 500 && ncyc < 5000) begin
      @(negedge CLK);
      took = IN_VALID && IN_READY;
      cyc();
      ncyc++;
      if (took) acc++;
      OUT_READY = ~OUT_READY;
      if (took || !IN_VALID) begin
        IN_VALID = (acc < 500) ? 1'($urandom_range(0, 1)) : 1'b0;
        IN_DATA = 16'($urandom);
      end
    end
    IN_VALID = 1'b0;
    chk("bp_accepted", acc, 500);
    OUT_READY = 1'b1;
    ncyc = 0;
    while (exp_q.size() != 0 && ncyc < 100) begin
      cyc();
      ncyc++;
    end
    @(negedge CLK);
    chk("bp_drained", exp_q.size(), 0);
    cyc();

    // Reset mid-stream
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      IN_VALID = 1'b1;
      IN_DATA = 16'h0050 + 16'(i);
      cyc();
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("mr_count5", COUNT, 5);
    cyc();
    RSTN = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    chk("mr_count0", COUNT, 0);
    chk("mr_valid0", OUT_VALID, 0);
    chk("mr_empty", EMPTY, 1);
    cyc();
    RSTN = 1'b1; OUT_READY = 1'b1;
    IN_VALID = 1'b1; IN_DATA = 16'h1234;
    @(negedge CLK);
`ifdef SCM_FIFO_BYPASS_EN
    chk("mr_we", MEM_WE, 0);
`else
    chk("mr_we", MEM_WE, 1);
    chk("mr_waddr", MEM_WADDR, 0);
`endif
    for (int c = 1; c <= LAT + 1; c++) begin
      cyc();
      IN_VALID = 1'b0;
      @(negedge CLK);
      chk("mr_valid", OUT_VALID, (c == LAT) ? 1 : 0);
      if (c == LAT) chk("mr_data", OUT_DATA, 16'h1234);
    end
    cyc();
    @(negedge CLK);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scm_fifo_ctrl.md
# scm_fifo_ctrl

Initiator-side controller for the 16x16 standard-cell memory macro (scm65). It turns the macro into a synchronous FIFO with valid/ready handshakes on both ends. It drives the macro's WE/WADDR/DIN write port and RE/RADDR read port, and absorbs the macro's one-cycle read latency in a 2-entry output stage. The block sits between a streaming producer/consumer and the memory macro.

## Interface
- DEPTH, 16, number of memory words; must equal the macro depth.
- AW, 4, memory address width; DEPTH = 2**AW.
- DW, 16, data width.
- CLK  in  1  single clock; also feeds the macro.
- RSTN  in  1  asynchronous active-low reset.
- IN_VALID  in  1  producer has a word.
- IN_READY  out  1  controller accepts a word.
- IN_DATA  in  DW  producer word.
- OUT_VALID  out  1  OUT_DATA holds a word.
- OUT_READY  in  1  consumer takes the word.
- OUT_DATA  out  DW  head word.
- MEM_WE  out  1  to macro WE.
- MEM_WADDR  out  AW  to macro WADDR.
- MEM_DIN  out  DW  to macro DIN.
- MEM_RE  out  1  to macro RE.
- MEM_RADDR  out  AW  to macro RADDR.
- MEM_DOUT  in  DW  from macro DOUT.
- COUNT  out  AW+2  total words held (memory + in flight + output stage), range 0..DEPTH+2.
- FULL  out  1  IN_READY low.
- EMPTY  out  1  COUNT == 0.

## Operation
- State: wptr, rptr (AW bits, wrap modulo DEPTH), mem_cnt (0..DEPTH), rd_inflight (1 bit), output stage occ (0..2).
- Push: IN_READY = (mem_cnt < DEPTH). When IN_VALID & IN_READY: MEM_WE=1, MEM_WADDR=wptr, MEM_DIN=IN_DATA combinationally in the same cycle. wptr increments at the edge.
- Read issue: MEM_RE=1 and MEM_RADDR=rptr when mem_cnt > 0 and (occ + rd_inflight − pop) < 2, where pop = OUT_VALID & OUT_READY. rptr increments and rd_inflight is set at the edge.
- Return: when rd_inflight=1, MEM_DOUT is written into the output stage at the next edge.
- mem_cnt update: +1 on push, −1 on read issue; both may occur in the same cycle (net 0).
- Output stage: 2-entry in-order buffer. OUT_VALID = (occ > 0). OUT_DATA = head entry, driven from registers, never directly from MEM_DOUT. Capture and pop may occur in the same cycle.
- A word written at edge t is readable from cycle t+1. Because mem_cnt is registered, a read never targets the address being written in the same cycle.
- FULL = !IN_READY. Capacity is DEPTH+2 words.
- Reset (async assert, sync deassert externally): pointers, counters, occ, rd_inflight and OUT_DATA = 0. Outputs: OUT_VALID=0, MEM_WE=0, MEM_RE=0, MEM_WADDR=0, MEM_RADDR=0, MEM_DIN=IN_DATA, COUNT=0, EMPTY=1, IN_READY=1, FULL=0.
- Reset mid-operation discards all contents. The memory array itself is not cleared.

## Timing
- Push in cycle 0 with an empty FIFO: MEM_RE in cycle 1, data captured at the end of cycle 2, OUT_VALID in cycle 3. Fall-through latency is 3 cycles.
- Steady state with OUT_READY=1: one word per cycle in each direction.
- OUT_DATA and OUT_VALID are stable while OUT_VALID & !OUT_READY.
- IN_READY depends only on registered state; there is no combinational path from OUT_READY to IN_READY.

## Configuration
- SCM_FIFO_BYPASS_EN defined: when mem_cnt=0, rd_inflight=0 and (occ − pop) < 2, an accepted push is written directly into the output stage. MEM_WE stays 0 for that push. Fall-through latency becomes 1 cycle, and ordering is preserved.
- Macro undefined: every word passes through the memory macro, and latency is 3 cycles.

## Structure
- Package scm_fifo_pkg holds: DEPTH/AW/DW defaults, a count_t typedef (AW+2 bits), and a ptr_t typedef (AW bits).
- Sub-module scm_fifo_ostage is the 2-entry output stage. It has a capture/valid input, OUT_VALID/OUT_READY/OUT_DATA and an occ output.
- The top level holds pointers, counters and read-issue logic.

## Test plan
- Reset: assert RSTN=0 with random inputs -> OUT_VALID=0, MEM_WE=0, MEM_RE=0, COUNT=0, EMPTY=1, IN_READY=1.
- Single word: push 0xA5A5 in cycle 0 with OUT_READY=1 -> MEM_WE/WADDR=0 in cycle 0, MEM_RE/RADDR=0 in cycle 1, OUT_VALID with 0xA5A5 in cycle 3, EMPTY again in cycle 4.
- Fill: OUT_READY=0, offer 0..19 back-to-back -> 18 words accepted, IN_READY=0, COUNT=18, FULL=1. Then OUT_READY=1 -> 0..17 emerge in order, one per cycle.
- Wrap and throughput: stream 40 words with both sides ready -> WADDR/RADDR wrap 15->0, one output per cycle after the 3-cycle latency, no loss.
- Backpressure: OUT_READY toggling every cycle plus random IN_VALID over 500 words -> scoreboard match, and OUT_DATA held while stalled.
- Reset mid-stream: at COUNT=5 pulse RSTN low -> COUNT=0, OUT_VALID=0. The next push of 0x1234 emerges first. With SCM_FIFO_BYPASS_EN, the same push appears in cycle 1 with MEM_WE=0.
